imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 256, meaning the number of instruction-memory words.
REQ-002 SHALL have parameter RAM_SIZE_BIT, default 8, meaning the instruction-memory address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: load request, sampled only in IDLE.
REQ-006 SHALL have port load_words, input, RAM_SIZE_BIT+1 bits: number of words to load, sampled with start.
REQ-007 SHALL have port byte_valid, input, 1 bit: byte_data is valid.
REQ-008 SHALL have port byte_data, input, 8 bits: incoming program byte.
REQ-009 SHALL have port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-010 SHALL have port mem_write, output, 1 bit: write strobe to instruction memory.
REQ-011 SHALL have port mem_address, output, RAM_SIZE_BIT bits: instruction-memory word address.
REQ-012 SHALL have port mem_write_data, output, 32 bits: assembled instruction word.
REQ-013 SHALL have port busy, output, 1 bit: load in progress; used to hold the CPU.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at load end.
REQ-015 SHALL have port load_err, output, 1 bit: result flag, valid from the done pulse until the next accepted start.

Function
REQ-016 SHALL implement the states IDLE, RECV, WRITE, CHECK and FIN.
REQ-017 SHALL treat a byte as transferred only on a clock edge where byte_valid and byte_ready are both 1.
REQ-018 SHALL drive byte_ready to 1 only in RECV and CHECK.
REQ-019 In IDLE with start=1 and 1<=load_words<=RAM_SIZE, SHALL latch load_words, clear the word index, byte index and checksum, clear load_err, and go to RECV.
REQ-020 In IDLE with start=1 and load_words=0 or load_words>RAM_SIZE, SHALL set load_err=1 and go to FIN with no write.
REQ-021 In RECV, SHALL place each transferred byte little-endian: byte 0 into bits 7:0, through byte 3 into bits 31:24.
REQ-022 In RECV, SHALL XOR each transferred byte into an 8-bit checksum.
REQ-023 On the 4th byte of a word, SHALL go to WRITE.
REQ-024 In WRITE, SHALL hold mem_write=1 for exactly one cycle, with mem_address equal to the word index and mem_write_data equal to the assembled word; both SHALL be registered and stable throughout that cycle.
REQ-025 Latency: the 4th-byte transfer on edge k SHALL give mem_write=1 during the cycle after edge k, with the memory committing on edge k+1.
REQ-026 After WRITE, SHALL increment the word index and go to RECV, or to CHECK if the index equals load_words; the address SHALL never exceed RAM_SIZE-1.
REQ-027 In CHECK, SHALL take one trailer byte and set load_err=1 if it differs from the checksum, else 0, then go to FIN.
REQ-028 FIN SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-029 busy SHALL be 1 in RECV, WRITE, CHECK and FIN, and 0 in IDLE.
REQ-030 SHALL ignore start outside IDLE.
REQ-031 SHALL accept byte_valid deasserting mid-word without loss of state; stalls are unbounded.
REQ-032 Outside WRITE, mem_write SHALL be 0; mem_address and mem_write_data SHALL hold their last values.

Reset
REQ-033 reset_n=0 SHALL immediately force state IDLE, with mem_write, busy, done, load_err and byte_ready all 0.
REQ-034 reset_n=0 SHALL immediately force mem_address, mem_write_data, indices and checksum to 0.
REQ-035 Reset mid-load SHALL abort with no further writes; words already written SHALL remain in memory.

Structure
REQ-036 SHALL place the state encoding (IDLE..FIN) and the byte-order constant in the shared CPU package.
REQ-037 SHALL contain no sub-module; the memory is written through the existing write port at the top level.

Verification
REQ-038 start, load_words=2, bytes 13 00 08 20 | 0C 00 00 00 | trailer 37 -> writes addr0=0x20080013, addr1=0x0000000C; done pulse; load_err=0.
REQ-039 Same stream with trailer 00 -> both words written; done with load_err=1.
REQ-040 load_words=0, and separately load_words=257 -> no mem_write; done one cycle after start; load_err=1; byte_ready stays 0.
REQ-041 byte_valid random gaps 0-5 cycles, load_words=256 -> 256 writes at addresses 0..255 in order; content matches the sent image; exactly one write per word.
REQ-042 reset_n low after word 1 of a 3-word load -> all outputs 0 immediately; addr0 keeps its value; a new start then completes normally.
REQ-043 start pulsed during RECV -> ignored; the load completes with the original count.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader.
//   - loader_state_e : FSM state encoding (IDLE, RECV, WRITE, CHECK, FIN)
//   - BYTE_ORDER_LITTLE : incoming byte stream is little-endian per word
//   - byte_lane()    : maps the n-th received byte of a word to its lane
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } loader_state_e;

  // 1: first byte of a word lands in bits 7:0; 0: first byte in bits 31:24.
  localparam bit BYTE_ORDER_LITTLE = 1'b1;

  // Lane (0 = bits 7:0 ... 3 = bits 31:24) that receives byte number idx.
  function automatic logic [1:0] byte_lane(input logic [1:0] idx);
    return BYTE_ORDER_LITTLE ? idx : ~idx;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Receives a program as a byte stream (valid/ready handshake), assembles
//   32-bit words and writes them to instruction memory from address 0 up.
//   The stream ends with one trailer byte that must equal the XOR of all
//   data bytes; a mismatch (or an illegal word count) raises load_err.
//
// Ports
//   clk            : clock, rising edge
//   reset_n        : asynchronous active-low reset
//   start          : load request, only looked at in IDLE
//   load_words     : number of words to load (1..RAM_SIZE), sampled with start
//   byte_valid     : byte_data carries a byte
//   byte_data      : program byte
//   byte_ready     : loader accepts a byte this cycle (RECV / CHECK)
//   mem_write      : one-cycle write strobe to instruction memory
//   mem_address    : word address for the write
//   mem_write_data : assembled instruction word
//   busy           : load in progress (hold the CPU)
//   done           : one-cycle pulse when a load ends
//   load_err       : result flag, valid from done until the next accepted start
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int RAM_SIZE     = 256,
  parameter int RAM_SIZE_BIT = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [RAM_SIZE_BIT:0]   load_words,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic                    byte_ready,
  output logic                    mem_write,
  output logic [RAM_SIZE_BIT-1:0] mem_address,
  output logic [31:0]             mem_write_data,
  output logic                    busy,
  output logic                    done,
  output logic                    load_err
);

  localparam logic [RAM_SIZE_BIT:0] LP_RAM_WORDS = (RAM_SIZE_BIT + 1)'(RAM_SIZE);
  localparam logic [RAM_SIZE_BIT:0] LP_ONE       = (RAM_SIZE_BIT + 1)'(1);

  loader_state_e           r_state;
  logic [RAM_SIZE_BIT:0]   r_count;
  logic [RAM_SIZE_BIT:0]   r_word_idx;
  logic [1:0]              r_byte_idx;
  logic [7:0]              r_csum;
  logic [31:0]             r_word;
  logic                    r_mem_write;
  logic [RAM_SIZE_BIT-1:0] r_mem_address;
  logic [31:0]             r_mem_write_data;
  logic                    r_done;
  logic                    r_load_err;

  logic                    w_xfer;
  logic                    w_len_ok;
  logic [RAM_SIZE_BIT:0]   w_idx_next;
  logic [31:0]             w_word_next;

  assign w_xfer     = byte_valid & byte_ready;
  assign w_len_ok   = (load_words != '0) && (load_words <= LP_RAM_WORDS);
  assign w_idx_next = r_word_idx + LP_ONE;

  // Current word with the incoming byte merged into its lane; used both to
  // update the assembly register and, on the 4th byte, as the write data.
  always_comb begin
    w_word_next = r_word;
    w_word_next[{byte_lane(r_byte_idx), 3'b000} +: 8] = byte_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_count          <= '0;
      r_word_idx       <= '0;
      r_byte_idx       <= '0;
      r_csum           <= '0;
      r_word           <= '0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_done           <= 1'b0;
      r_load_err       <= 1'b0;
    end else begin
      // Strobes default low; each is raised only on entry to its state.
      r_mem_write <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_len_ok) begin
              r_count    <= load_words;
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_csum     <= '0;
              r_word     <= '0;
              r_load_err <= 1'b0;
              r_state    <= RECV;
            end else begin
              r_load_err <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= FIN;
            end
          end
        end
        RECV: begin
          if (w_xfer) begin
            r_word     <= w_word_next;
            r_csum     <= r_csum ^ byte_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              // Address and data are registered here so both are stable
              // for the whole WRITE cycle while mem_write is high.
              r_mem_write      <= 1'b1;
              r_mem_address    <= r_word_idx[RAM_SIZE_BIT-1:0];
              r_mem_write_data <= w_word_next;
              r_state          <= WRITE;
            end
          end
        end
        WRITE: begin
          r_word_idx <= w_idx_next;
          r_state    <= (w_idx_next == r_count) ? CHECK : RECV;
        end
        CHECK: begin
          if (w_xfer) begin
            r_load_err <= (byte_data != r_csum);
            r_done     <= 1'b1;
            r_state    <= FIN;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign byte_ready     = (r_state == RECV) || (r_state == CHECK);
  assign busy           = (r_state != IDLE);
  assign mem_write      = r_mem_write;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign done           = r_done;
  assign load_err       = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed sequence of loads with randomized images and byte gaps. The
//   expected write list, checksum and error flag come from the word image
//   held in the bench; an always block records every write the DUT issues
//   into a behavioural memory and a write log.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int RS = 256;
  localparam int RB = 8;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [RB:0]   load_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_write;
  logic [RB-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic          busy;
  logic          done;
  logic          load_err;

  imem_loader #(.RAM_SIZE(RS), .RAM_SIZE_BIT(RB)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .load_words     (load_words),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .busy           (busy),
    .done           (done),
    .load_err       (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]   img     [0:RS-1];
  logic [31:0]   mem_obs [0:RS-1];
  logic [RB-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];

  // Instruction memory as seen by the CPU: commits whatever the strobe says.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      obs_addr.push_back(mem_address);
      obs_data.push_back(mem_write_data);
      mem_obs[mem_address] <= mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; leaves at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("byte_ready_wait", byte_ready, 1'b1);
    if (byte_ready === 1'b1) @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input int n, input int maxgap, input bit good_trailer,
                          input logic [7:0] trailer_in, input bit poke_start,
                          input string name);
    logic [7:0] cs;
    logic [7:0] trailer;
    bit         exp_err;
    cs = 8'h00;
    for (int w = 0; w < n; w++)
      for (int j = 0; j < 4; j++)
        cs ^= 8'(img[w] >> (8 * j));
    trailer = good_trailer ? cs : trailer_in;
    exp_err = (trailer != cs);
    obs_addr.delete();
    obs_data.delete();

    start      = 1'b1;
    load_words = (RB + 1)'(n);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_recv"}, busy, 1'b1);
    chk({name, "_ready_recv"}, byte_ready, 1'b1);
    chk({name, "_err_cleared"}, load_err, 1'b0);

    for (int w = 0; w < n; w++) begin
      for (int j = 0; j < 4; j++) begin
        if (poke_start && w == 0 && j == 2) begin
          start      = 1'b1;
          load_words = (RB + 1)'(5);
          @(negedge clk);
          start = 1'b0;
        end
        send_byte(8'(img[w] >> (8 * j)), $urandom_range(0, maxgap));
      end
    end
    send_byte(trailer, $urandom_range(0, maxgap));

    chk({name, "_done"}, done, 1'b1);
    chk({name, "_err"}, load_err, exp_err);
    chk({name, "_busy_fin"}, busy, 1'b1);
    @(negedge clk);
    chk({name, "_done_drop"}, done, 1'b0);
    chk({name, "_idle"}, busy, 1'b0);
    chk({name, "_err_hold"}, load_err, exp_err);

    chk({name, "_wr_count"}, obs_addr.size(), n);
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", name, i), obs_addr[i], i);
      chk($sformatf("%s_data%0d", name, i), obs_data[i], img[i]);
      chk($sformatf("%s_mem%0d", name, i), mem_obs[i], img[i]);
    end
    $display("load %s: words=%0d trailer=%02h checksum=%02h writes=%0d load_err=%0b",
             name, n, trailer, cs, obs_addr.size(), load_err);
  endtask

  task automatic bad_len(input int n, input string name);
    obs_addr.delete();
    obs_data.delete();
    start      = 1'b1;
    load_words = (RB + 1)'(n);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_err"}, load_err, 1'b1);
    chk({name, "_ready"}, byte_ready, 1'b0);
    chk({name, "_busy"}, busy, 1'b1);
    @(negedge clk);
    chk({name, "_done_drop"}, done, 1'b0);
    chk({name, "_idle"}, busy, 1'b0);
    chk({name, "_err_hold"}, load_err, 1'b1);
    chk({name, "_ready_idle"}, byte_ready, 1'b0);
    chk({name, "_no_write"}, obs_addr.size(), 0);
    $display("load %s: load_words=%0d rejected, writes=%0d load_err=%0b",
             name, n, obs_addr.size(), load_err);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_mem_write"}, mem_write, 1'b0);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_done"}, done, 1'b0);
    chk({name, "_load_err"}, load_err, 1'b0);
    chk({name, "_byte_ready"}, byte_ready, 1'b0);
    chk({name, "_addr"}, mem_address, 0);
    chk({name, "_wdata"}, mem_write_data, 0);
  endtask

  initial begin
    reset_n    = 1'b1;
    start      = 1'b0;
    load_words = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    $display("reset: outputs checked in reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Reference program from the requirements: checksum is 0x37.
    img[0] = 32'h20080013;
    img[1] = 32'h0000000C;
    run_load(2, 0, 1'b0, 8'h37, 1'b0, "good_trailer");
    run_load(2, 1, 1'b0, 8'h00, 1'b0, "bad_trailer");

    bad_len(0, "len0");
    bad_len(257, "len257");

    for (int i = 0; i < RS; i++) img[i] = $urandom;
    run_load(RS, 5, 1'b1, 8'h00, 1'b0, "full256");

    for (int i = 0; i < 4; i++) img[i] = $urandom;
    run_load(4, 3, 1'b0, 8'($urandom), 1'b0, "rand_trailer");

    // Abort a 3-word load after the first word has been written.
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    obs_addr.delete();
    obs_data.delete();
    start      = 1'b1;
    load_words = (RB + 1)'(3);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 4; j++) send_byte(8'(img[0] >> (8 * j)), 0);
    @(negedge clk);
    send_byte(8'(img[1]), 0);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) @(negedge clk);
    chk("abort_wr_count", obs_addr.size(), 1);
    chk("abort_addr0_kept", mem_obs[0], img[0]);
    chk("abort_no_write", mem_write, 1'b0);
    $display("load abort: reset after word 0, writes=%0d addr0=%08h", obs_addr.size(), mem_obs[0]);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    run_load(3, 2, 1'b1, 8'h00, 1'b0, "after_abort");

    for (int i = 0; i < 2; i++) img[i] = $urandom;
    run_load(2, 2, 1'b1, 8'h00, 1'b1, "start_in_recv");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
